// File: rtl/xgmii_encoder.sv
// Transmit-side 64b/66b encoder: pairs two 32-bit XGMII beats into one 64-bit word and
// emits the matching 66-bit PCS block through a single-entry valid/ready output register.
module xgmii_encoder #(
    parameter int unsigned PCS_DATA_WIDTH   = 66,
    parameter int unsigned XGMII_DATA_WIDTH = 32,
    parameter int unsigned XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0] xgmii_data_in,
    input  logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_in,
    input  logic                        xgmii_valid_in,
    output logic                        xgmii_ready_out,
    output logic [PCS_DATA_WIDTH-1:0]   encoded_data_out,
    output logic                        encoded_valid_out,
    input  logic                        encoded_ready_in,
    output logic                        encode_error_out
);

    localparam logic IN_LOW  = 1'b0;
    localparam logic IN_HIGH = 1'b1;

    logic                        in_state_q, in_state_d;
    logic [XGMII_DATA_WIDTH-1:0] lo_data_q, lo_data_d;
    logic [XGMII_DATA_BYTES-1:0] lo_ctrl_q, lo_ctrl_d;
    logic [PCS_DATA_WIDTH-1:0]   out_q, out_d;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;
    logic                        accept;
    logic [PCS_DATA_WIDTH:0]     enc;

    // Returns {error, block}; anything not matching a legal pattern becomes an error block.
    function automatic logic [66:0] encode(input logic [63:0] d, input logic [7:0] c);
        logic [66:0] r;
        logic [7:0]  tmask;
        logic [63:0] pmask;
        logic        tail_ok;
        logic        found;
        logic [7:0]  ttype [8];
        ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        r     = {1'b1, 2'b10, 8'h1E, {8{7'h1E}}};
        found = 1'b0;
        if (c == 8'h00) begin
            r = {1'b0, 2'b01, d};
        end else if (c == 8'hFF && d == {8{8'h07}}) begin
            r = {1'b0, 2'b10, 8'h1E, 8'h07, 48'h0};
        end else if (c == 8'h01 && d[7:0] == 8'hFB) begin
            r = {1'b0, 2'b10, 8'h78, d[63:8]};
        end else if (c == 8'h1F && d[31:0] == {4{8'h07}} && d[39:32] == 8'hFB) begin
            r = {1'b0, 2'b10, 8'h33, 32'h0, d[63:40]};
        end else begin
            for (int k = 0; k < 8; k++) begin
                tmask   = 8'hFF << k;
                tail_ok = 1'b1;
                for (int j = k + 1; j < 8; j++) begin
                    if (d[8*j +: 8] != 8'h07) tail_ok = 1'b0;
                end
                if (!found && c == tmask && d[8*k +: 8] == 8'hFD && tail_ok) begin
                    found = 1'b1;
                    pmask = (64'd1 << (8 * k)) - 64'd1;
                    r     = {1'b0, 2'b10, ttype[k], d[55:0] & pmask[55:0]};
                end
            end
        end
        return r;
    endfunction

    assign xgmii_ready_out = (in_state_q == IN_LOW) | ~valid_q | encoded_ready_in;
    assign accept          = xgmii_valid_in & xgmii_ready_out;
    assign enc             = encode({xgmii_data_in, lo_data_q}, {xgmii_ctrl_in, lo_ctrl_q});

    always_comb begin
        in_state_d = in_state_q;
        lo_data_d  = lo_data_q;
        lo_ctrl_d  = lo_ctrl_q;
        out_d      = out_q;
        valid_d    = valid_q;
        err_d      = err_q;
        if (valid_q && encoded_ready_in) begin
            out_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end
        if (accept) begin
            if (in_state_q == IN_LOW) begin
                lo_data_d  = xgmii_data_in;
                lo_ctrl_d  = xgmii_ctrl_in;
                in_state_d = IN_HIGH;
            end else begin
                in_state_d     = IN_LOW;
                {err_d, out_d} = enc;
                valid_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            in_state_q <= IN_LOW;
            lo_data_q  <= '0;
            lo_ctrl_q  <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            lo_data_q  <= lo_data_d;
            lo_ctrl_q  <= lo_ctrl_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign encoded_data_out  = out_q;
    assign encoded_valid_out = valid_q;
    assign encode_error_out  = err_q;

endmodule

// File: tb/tb_xgmii_encoder.sv
// Directed and randomized checks of xgmii_encoder against a lane-level reference encoder.
module tb_xgmii_encoder;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [31:0] xgmii_data_in;
    logic [3:0]  xgmii_ctrl_in;
    logic        xgmii_valid_in;
    logic        xgmii_ready_out;
    logic [65:0] encoded_data_out;
    logic        encoded_valid_out;
    logic        encoded_ready_in;
    logic        encode_error_out;

    int n_vec = 0;
    int n_err = 0;

    xgmii_encoder dut (
        .tx_clk            (tx_clk),
        .tx_rst            (tx_rst),
        .xgmii_data_in     (xgmii_data_in),
        .xgmii_ctrl_in     (xgmii_ctrl_in),
        .xgmii_valid_in    (xgmii_valid_in),
        .xgmii_ready_out   (xgmii_ready_out),
        .encoded_data_out  (encoded_data_out),
        .encoded_valid_out (encoded_valid_out),
        .encoded_ready_in  (encoded_ready_in),
        .encode_error_out  (encode_error_out)
    );

    always #5 tx_clk = ~tx_clk;

    localparam logic [66:0] ERR_BLK = {1'b1, 2'b10, 8'h1E, {8{7'h1E}}};

    // Reference: {error, block} from lane bytes and control bits.
    function automatic logic [66:0] ref_enc(input logic [63:0] d, input logic [7:0] c);
        logic [7:0]  ln [8];
        logic [7:0]  types [8];
        logic [55:0] pay;
        logic [7:0]  want;
        int          k;
        bit          ok;
        types = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        if (c == 8'h00) return {1'b0, 2'b01, d};
        ok = 1;
        for (int i = 0; i < 8; i++) if (ln[i] != 8'h07) ok = 0;
        if (c == 8'hFF && ok) return {1'b0, 2'b10, 8'h1E, 8'h07, 48'h0};
        if (c == 8'h01 && ln[0] == 8'hFB) return {1'b0, 2'b10, 8'h78, d[63:8]};
        if (c == 8'h1F && ln[0] == 8'h07 && ln[1] == 8'h07 && ln[2] == 8'h07 &&
            ln[3] == 8'h07 && ln[4] == 8'hFB)
            return {1'b0, 2'b10, 8'h33, 32'h0, d[63:40]};
        // Terminate lane is the first control lane; every lane from there up must be control.
        k = 0;
        for (int i = 7; i >= 0; i--) if (c[i]) k = i;
        want = 8'hFF << k;
        ok   = (c == want) && (ln[k] == 8'hFD);
        for (int i = k + 1; i < 8; i++) if (ln[i] != 8'h07) ok = 0;
        if (!ok) return ERR_BLK;
        pay = '0;
        for (int i = 0; i < k; i++) pay[8*i +: 8] = ln[i];
        return {1'b0, 2'b10, types[k], pay};
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge with encoded_ready_in=1; returns #1 after the high-beat edge.
    task automatic send_pair(input logic [63:0] d, input logic [7:0] c, input string tag,
                             output logic [66:0] e);
        e              = ref_enc(d, c);
        xgmii_valid_in = 1'b1;
        xgmii_data_in  = d[31:0];
        xgmii_ctrl_in  = c[3:0];
        @(posedge tx_clk); #1;
        chk({tag, "/lat"}, 67'(encoded_valid_out), 67'd0);
        xgmii_data_in  = d[63:32];
        xgmii_ctrl_in  = c[7:4];
        @(posedge tx_clk); #1;
        xgmii_valid_in = 1'b0;
        chk({tag, "/blk"}, {encode_error_out, encoded_data_out}, e);
        chk({tag, "/vld"}, 67'(encoded_valid_out), 67'd1);
    endtask

    task automatic gen_word(output logic [63:0] d, output logic [7:0] c);
        int cat;
        int k;
        cat = $urandom_range(0, 6);
        d   = {$urandom, $urandom};
        k   = $urandom_range(0, 7);
        case (cat)
            0: c = 8'h00;
            1: begin d = {8{8'h07}}; c = 8'hFF; end
            2: begin d[7:0] = 8'hFB; c = 8'h01; end
            3: begin d[31:0] = {4{8'h07}}; d[39:32] = 8'hFB; c = 8'h1F; end
            4, 5: begin
                c = 8'hFF << k;
                d[8*k +: 8] = (cat == 4) ? 8'hFD : 8'h55;
                for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
            end
            default: c = 8'($urandom);
        endcase
    endtask

    initial begin
        logic [66:0] e, ea;
        logic [63:0] d, db;
        logic [7:0]  c, cb;
        int          n;

        tx_rst           = 1'b1;
        xgmii_data_in    = '0;
        xgmii_ctrl_in    = '0;
        xgmii_valid_in   = 1'b0;
        encoded_ready_in = 1'b1;
        #12;
        chk("rst_out", {encode_error_out, encoded_data_out}, 67'd0);
        chk("rst_vld", 67'(encoded_valid_out), 67'd0);
        chk("rst_rdy", 67'(xgmii_ready_out), 67'd1);
        @(negedge tx_clk) tx_rst = 1'b0;
        @(posedge tx_clk); #1;

        send_pair(64'h07070707_07070707, 8'hFF, "idle", e);
        chk("idle_const", {encode_error_out, encoded_data_out}, {1'b0, 66'h2_1E07_0000_0000_0000});
        send_pair(64'h07060504_03020100, 8'h00, "data", e);
        chk("data_const", {encode_error_out, encoded_data_out}, {1'b0, 66'h1_0706050403020100});
        send_pair(64'h07060504_030201FB, 8'h01, "s0", e);
        chk("s0_const", {encode_error_out, encoded_data_out},
            {1'b0, 2'b10, 8'h78, 56'h07060504030201});
        send_pair(64'h07070707_FD020100, 8'hF8, "t3", e);
        chk("t3_const", {encode_error_out, encoded_data_out},
            {1'b0, 2'b10, 8'hB4, 56'h020100});
        send_pair(64'h07060504_03020155, 8'h01, "err", e);
        chk("err_const", {encode_error_out, encoded_data_out}, ERR_BLK);
        send_pair(64'hDDCCBBFB_07070707, 8'h1F, "s4", e);
        chk("s4_const", {encode_error_out, encoded_data_out},
            {1'b0, 2'b10, 8'h33, 32'h0, 24'hDDCCBB});

        // Backpressure: block A held while block B's high beat stalls.
        @(posedge tx_clk); #1;
        encoded_ready_in = 1'b0;
        d  = 64'h1122334455667788;
        c  = 8'h00;
        db = 64'h07070707_07FD2211;
        cb = 8'hFC;
        ea = ref_enc(d, c);
        xgmii_valid_in = 1'b1;
        xgmii_data_in  = d[31:0];
        xgmii_ctrl_in  = c[3:0];
        @(posedge tx_clk); #1;
        xgmii_data_in  = d[63:32];
        xgmii_ctrl_in  = c[7:4];
        @(posedge tx_clk); #1;
        xgmii_data_in  = db[31:0];
        xgmii_ctrl_in  = cb[3:0];
        @(posedge tx_clk); #1;
        xgmii_data_in  = db[63:32];
        xgmii_ctrl_in  = cb[7:4];
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {encode_error_out, encoded_data_out}, ea);
            chk("bp_vld", 67'(encoded_valid_out), 67'd1);
            chk("bp_rdy", 67'(xgmii_ready_out), 67'd0);
            @(posedge tx_clk); #1;
        end
        encoded_ready_in = 1'b1;
        #1;
        chk("bp_rdy_rel", 67'(xgmii_ready_out), 67'd1);
        @(posedge tx_clk); #1;
        xgmii_valid_in = 1'b0;
        chk("bp_next", {encode_error_out, encoded_data_out}, ref_enc(db, cb));
        chk("bp_next_vld", 67'(encoded_valid_out), 67'd1);

        for (int i = 0; i < 60; i++) begin
            gen_word(d, c);
            send_pair(d, c, "rand", e);
            if ($urandom_range(0, 3) == 0) begin
                encoded_ready_in = 1'b0;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    @(posedge tx_clk); #1;
                    chk("rand_hold", {encode_error_out, encoded_data_out}, e);
                    chk("rand_hold_vld", 67'(encoded_valid_out), 67'd1);
                end
                encoded_ready_in = 1'b1;
            end
        end

        // Reset with a held block and a pending low beat.
        send_pair(64'h0F0E0D0C_0B0A0908, 8'h00, "pre_rst", e);
        encoded_ready_in = 1'b0;
        xgmii_valid_in   = 1'b1;
        xgmii_data_in    = 32'hAABBCCDD;
        xgmii_ctrl_in    = 4'h0;
        @(posedge tx_clk); #1;
        xgmii_valid_in   = 1'b0;
        #2 tx_rst = 1'b1;
        #1;
        chk("mid_rst_out", {encode_error_out, encoded_data_out}, 67'd0);
        chk("mid_rst_vld", 67'(encoded_valid_out), 67'd0);
        chk("mid_rst_rdy", 67'(xgmii_ready_out), 67'd1);
        @(negedge tx_clk) tx_rst = 1'b0;
        encoded_ready_in = 1'b1;
        @(posedge tx_clk); #1;
        send_pair(64'h07070707_FD030201, 8'hF8, "post_rst", e);
        chk("post_rst_const", {encode_error_out, encoded_data_out},
            {1'b0, 2'b10, 8'hB4, 56'h030201});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
